viewport_update_ctrl: RTL and testbench
=======================================

// Module: viewport_update_ctrl
// PURPOSE
//  Per-frame sequencer for camera basis generation. On each frame_start it latches the
//  player angles and drives them to angle_relative. After a settle window it captures the
//  look-at vectors and computes vp_u/vp_v/vp_origin on ONE shared 16x16 signed multiplier.
//  All nine outputs commit atomically, so the ray caster never sees a torn basis mid-frame.
// PARAMETERS
//  H_DISP     1280  horizontal display width (pixels)
//  V_DISP     720   vertical display height (pixels)
//  SCALE      225   fixed-point unit length of look-at vectors
//  SETTLE_CYC 2     cycles allowed for angle_relative to settle (>=1)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   reset: synchronous, active-high
//  frame_start    in   1   one-cycle pulse at start of vertical blank
//  p_angle_x      in   16  signed player yaw
//  p_angle_y      in   16  signed player pitch
//  ang_x_o        out  16  latched yaw, drives angle_relative.angle_x
//  ang_y_o        out  16  latched pitch, drives angle_relative.angle_y
//  lookat_rel_x/y/z in 16  signed look-at vector returned by angle_relative
//  lookat_h_rel_x/y in 16  signed horizontal look-at returned by angle_relative
//  vp_origin_x/y/z out 16  signed viewport origin (committed)
//  vp_u_x/y/z     out  16  signed horizontal basis (committed)
//  vp_v_x/y/z     out  16  signed vertical basis (committed)
//  vp_valid       out  1   one-cycle pulse in the cycle the new outputs first appear
//  busy           out  1   high in every state except IDLE
//  overrun        out  1   sticky; set when frame_start arrives while busy
// BEHAVIOUR
//  Reset: state=IDLE. All vp_* outputs, ang_*_o, vp_valid, busy, overrun = 0.
//   rst overrides frame_start in the same cycle. rst mid-operation aborts: no vp_valid,
//   outputs zeroed on the next edge.
//  FSM: IDLE -(frame_start)-> SETTLE (SETTLE_CYC cycles) -> CAPTURE (1) -> CROSS (6)
//   -> ORIGIN (6) -> COMMIT (1) -> IDLE.
//   - The IDLE->SETTLE edge latches p_angle_* into ang_*_o. Angle inputs are ignored
//     until the next frame_start.
//   - CAPTURE registers lookat_* into working regs L, H. It sets u=(H_y,-H_x,0).
//   - CROSS: one product per cycle, order uy*Lz, uz*Ly, uz*Lx, ux*Lz, ux*Ly, uy*Lx.
//     Then v_x=(p0-p1)/SCALE, v_y=(p2-p3)/SCALE, v_z=(p4-p5)/SCALE.
//   - ORIGIN: per axis a in x,y,z, two products -u_a*H_DISP then v_a*V_DISP.
//     Then o_a=(L_a + ((-u_a*H_DISP + v_a*V_DISP)/2)/SCALE)*2.
//   - COMMIT: u, v, o copied to vp_* together; vp_valid=1 for exactly this one cycle.
//  Latency: frame_start sampled at edge k -> vp_* update and vp_valid high after edge
//   k+SETTLE_CYC+14. With the default SETTLE_CYC this is 16 cycles.
//  Arithmetic: products are 32-bit signed; the accumulator is 40-bit signed.
//   Every division is signed and truncates toward zero (Verilog '/'); divisions are
//   applied in the order written. Results are kept as the low 16 bits (wrap, no saturation).
//  frame_start while busy: ignored and the current job completes unchanged; overrun<=1.
//   overrun is cleared only by rst.
//  vp_* hold their last committed values between commits.
// TESTING
//  1 L=(225,0,0),H=(225,0) -> u=(0,-225,0) v=(0,0,225) o=(450,1280,720), vp_valid @k+16
//  2 L=(0,225,0),H=(0,225) -> u=(225,0,0) v=(0,0,225) o=(-1280,450,720)
//  3 L=(100,0,37),H=(100,0) -> v=(-16,0,44) (trunc toward 0), o=(150,568,214)
//  4 Second frame_start 5 cycles after first -> ignored, overrun=1, one vp_valid, case-1 values
//  5 rst asserted during ORIGIN -> next cycle all outputs 0, busy=0, no vp_valid
//  6 Change p_angle_* 1 cycle after frame_start -> ang_*_o hold first values until next frame

Source files
------------

// File: rtl/viewport_update_ctrl.sv
// Per-frame camera basis sequencer: latches player angles, captures the look-at vectors and
// builds vp_u / vp_v / vp_origin on one shared 16x16 multiplier, committing all nine at once.
module viewport_update_ctrl #(
    parameter int unsigned H_DISP     = 1280,
    parameter int unsigned V_DISP     = 720,
    parameter int unsigned SCALE      = 225,
    parameter int unsigned SETTLE_CYC = 2,
    localparam int unsigned DW        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic signed [DW-1:0] p_angle_x,
    input  logic signed [DW-1:0] p_angle_y,
    output logic signed [DW-1:0] ang_x_o,
    output logic signed [DW-1:0] ang_y_o,
    input  logic signed [DW-1:0] lookat_rel_x,
    input  logic signed [DW-1:0] lookat_rel_y,
    input  logic signed [DW-1:0] lookat_rel_z,
    input  logic signed [DW-1:0] lookat_h_rel_x,
    input  logic signed [DW-1:0] lookat_h_rel_y,
    output logic signed [DW-1:0] vp_origin_x,
    output logic signed [DW-1:0] vp_origin_y,
    output logic signed [DW-1:0] vp_origin_z,
    output logic signed [DW-1:0] vp_u_x,
    output logic signed [DW-1:0] vp_u_y,
    output logic signed [DW-1:0] vp_u_z,
    output logic signed [DW-1:0] vp_v_x,
    output logic signed [DW-1:0] vp_v_y,
    output logic signed [DW-1:0] vp_v_z,
    output logic                 vp_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned PW         = 32;
    localparam int unsigned AW         = 40;
    localparam int unsigned CW         = (SETTLE_CYC > 6) ? $clog2(SETTLE_CYC) + 1 : 3;
    localparam int unsigned PROD_STEPS = 6;

    localparam logic signed [AW-1:0] SCALE_S  = AW'(SCALE);
    localparam logic signed [AW-1:0] TWO_S    = AW'(2);
    localparam logic signed [DW-1:0] H_DISP_S = DW'(H_DISP);
    localparam logic signed [DW-1:0] V_DISP_S = DW'(V_DISP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_CROSS,
        S_ORIGIN,
        S_COMMIT
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic signed [DW-1:0] ang_x_q, ang_x_d, ang_y_q, ang_y_d;
    logic signed [DW-1:0] l_q [3];
    logic signed [DW-1:0] l_d [3];
    logic signed [DW-1:0] u_q [3];
    logic signed [DW-1:0] u_d [3];
    logic signed [DW-1:0] v_q [3];
    logic signed [DW-1:0] v_d [3];
    logic signed [DW-1:0] o_q [3];
    logic signed [DW-1:0] o_d [3];
    logic signed [AW-1:0] acc_q, acc_d;

    logic signed [DW-1:0] vp_u_q [3];
    logic signed [DW-1:0] vp_u_d [3];
    logic signed [DW-1:0] vp_v_q [3];
    logic signed [DW-1:0] vp_v_d [3];
    logic signed [DW-1:0] vp_o_q [3];
    logic signed [DW-1:0] vp_o_d [3];
    logic vp_valid_q, vp_valid_d;
    logic busy_q, busy_d;
    logic overrun_q, overrun_d;

    logic [1:0]           axis;
    logic signed [DW-1:0] mul_a, mul_b;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] sum, quot;

    // Two products per vector component: even step primes the accumulator, odd step resolves it
    assign axis = cnt_q[2:1];

    // Shared multiplier operand routing
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state_q == S_CROSS) begin
            case (cnt_q[2:0])
                3'd0:    begin mul_a = u_q[1]; mul_b = l_q[2]; end
                3'd1:    begin mul_a = u_q[2]; mul_b = l_q[1]; end
                3'd2:    begin mul_a = u_q[2]; mul_b = l_q[0]; end
                3'd3:    begin mul_a = u_q[0]; mul_b = l_q[2]; end
                3'd4:    begin mul_a = u_q[0]; mul_b = l_q[1]; end
                3'd5:    begin mul_a = u_q[1]; mul_b = l_q[0]; end
                default: ;
            endcase
        end else if (state_q == S_ORIGIN) begin
            if (!cnt_q[0]) begin
                mul_a = u_q[axis];
                mul_b = H_DISP_S;
            end else begin
                mul_a = v_q[axis];
                mul_b = V_DISP_S;
            end
        end
    end

    assign prod = PW'(mul_a) * PW'(mul_b);

    // State register and all working/output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ang_x_q    <= '0;
            ang_y_q    <= '0;
            l_q        <= '{default: '0};
            u_q        <= '{default: '0};
            v_q        <= '{default: '0};
            o_q        <= '{default: '0};
            acc_q      <= '0;
            vp_u_q     <= '{default: '0};
            vp_v_q     <= '{default: '0};
            vp_o_q     <= '{default: '0};
            vp_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ang_x_q    <= ang_x_d;
            ang_y_q    <= ang_y_d;
            l_q        <= l_d;
            u_q        <= u_d;
            v_q        <= v_d;
            o_q        <= o_d;
            acc_q      <= acc_d;
            vp_u_q     <= vp_u_d;
            vp_v_q     <= vp_v_d;
            vp_o_q     <= vp_o_d;
            vp_valid_q <= vp_valid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ang_x_d    = ang_x_q;
        ang_y_d    = ang_y_q;
        l_d        = l_q;
        u_d        = u_q;
        v_d        = v_q;
        o_d        = o_q;
        acc_d      = acc_q;
        vp_u_d     = vp_u_q;
        vp_v_d     = vp_v_q;
        vp_o_d     = vp_o_q;
        vp_valid_d = 1'b0;
        overrun_d  = overrun_q | (frame_start && (state_q != S_IDLE));
        sum        = '0;
        quot       = '0;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                    ang_x_d = p_angle_x;
                    ang_y_d = p_angle_y;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CAPTURE: begin
                l_d[0]  = lookat_rel_x;
                l_d[1]  = lookat_rel_y;
                l_d[2]  = lookat_rel_z;
                u_d[0]  = lookat_h_rel_y;
                u_d[1]  = -lookat_h_rel_x;
                u_d[2]  = '0;
                cnt_d   = '0;
                state_d = S_CROSS;
            end
            S_CROSS: begin
                if (!cnt_q[0]) begin
                    acc_d = AW'(prod);
                end else begin
                    sum       = acc_q - AW'(prod);
                    quot      = sum / SCALE_S;
                    v_d[axis] = DW'(quot);
                end
                if (cnt_q == CW'(PROD_STEPS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_ORIGIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ORIGIN: begin
                if (!cnt_q[0]) begin
                    acc_d = -AW'(prod);
                end else begin
                    sum       = acc_q + AW'(prod);
                    quot      = (sum / TWO_S) / SCALE_S;
                    o_d[axis] = DW'((AW'(l_q[axis]) + quot) <<< 1);
                end
                if (cnt_q == CW'(PROD_STEPS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_COMMIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_COMMIT: begin
                vp_u_d     = u_q;
                vp_v_d     = v_q;
                vp_o_d     = o_q;
                vp_valid_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign ang_x_o     = ang_x_q;
    assign ang_y_o     = ang_y_q;
    assign vp_u_x      = vp_u_q[0];
    assign vp_u_y      = vp_u_q[1];
    assign vp_u_z      = vp_u_q[2];
    assign vp_v_x      = vp_v_q[0];
    assign vp_v_y      = vp_v_q[1];
    assign vp_v_z      = vp_v_q[2];
    assign vp_origin_x = vp_o_q[0];
    assign vp_origin_y = vp_o_q[1];
    assign vp_origin_z = vp_o_q[2];
    assign vp_valid    = vp_valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_viewport_update_ctrl.sv
// Bench for viewport_update_ctrl: directed and random frames checked against an arithmetic
// model of the camera basis, plus overrun, reset-abort and angle-latch scenarios.
module tb_viewport_update_ctrl;

    localparam int LAT = 16;

    logic clk = 1'b0;
    logic rst;
    logic frame_start;
    logic signed [15:0] p_angle_x, p_angle_y, ang_x_o, ang_y_o;
    logic signed [15:0] lookat_rel_x, lookat_rel_y, lookat_rel_z;
    logic signed [15:0] lookat_h_rel_x, lookat_h_rel_y;
    logic signed [15:0] vp_origin_x, vp_origin_y, vp_origin_z;
    logic signed [15:0] vp_u_x, vp_u_y, vp_u_z;
    logic signed [15:0] vp_v_x, vp_v_y, vp_v_z;
    logic vp_valid, busy, overrun;

    int checks = 0;
    int errors = 0;

    shortint exp_u [3];
    shortint exp_v [3];
    shortint exp_o [3];
    shortint nxt_u [3];
    shortint nxt_v [3];
    shortint nxt_o [3];
    logic    exp_overrun;
    shortint exp_ax, exp_ay;

    viewport_update_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .p_angle_x      (p_angle_x),
        .p_angle_y      (p_angle_y),
        .ang_x_o        (ang_x_o),
        .ang_y_o        (ang_y_o),
        .lookat_rel_x   (lookat_rel_x),
        .lookat_rel_y   (lookat_rel_y),
        .lookat_rel_z   (lookat_rel_z),
        .lookat_h_rel_x (lookat_h_rel_x),
        .lookat_h_rel_y (lookat_h_rel_y),
        .vp_origin_x    (vp_origin_x),
        .vp_origin_y    (vp_origin_y),
        .vp_origin_z    (vp_origin_z),
        .vp_u_x         (vp_u_x),
        .vp_u_y         (vp_u_y),
        .vp_u_z         (vp_u_z),
        .vp_v_x         (vp_v_x),
        .vp_v_y         (vp_v_y),
        .vp_v_z         (vp_v_z),
        .vp_valid       (vp_valid),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic shortint w16(input longint x);
        return shortint'(x);
    endfunction

    // Camera basis straight from the defining formulas, truncating division, 16-bit wrap
    task automatic model(input shortint lx, input shortint ly, input shortint lz,
                         input shortint hx, input shortint hy);
        longint u [3];
        longint v [3];
        longint l [3];
        l[0] = lx; l[1] = ly; l[2] = lz;
        u[0] = hy;
        u[1] = w16(-longint'(hx));
        u[2] = 0;
        v[0] = w16((u[1] * l[2] - u[2] * l[1]) / 225);
        v[1] = w16((u[2] * l[0] - u[0] * l[2]) / 225);
        v[2] = w16((u[0] * l[1] - u[1] * l[0]) / 225);
        for (int a = 0; a < 3; a++) begin
            nxt_u[a] = w16(u[a]);
            nxt_v[a] = w16(v[a]);
            nxt_o[a] = w16((l[a] + ((-u[a] * 1280 + v[a] * 720) / 2) / 225) * 2);
        end
    endtask

    task automatic check_vp(input string tag);
        chk({tag, "/u_x"}, vp_u_x, exp_u[0]);
        chk({tag, "/u_y"}, vp_u_y, exp_u[1]);
        chk({tag, "/u_z"}, vp_u_z, exp_u[2]);
        chk({tag, "/v_x"}, vp_v_x, exp_v[0]);
        chk({tag, "/v_y"}, vp_v_y, exp_v[1]);
        chk({tag, "/v_z"}, vp_v_z, exp_v[2]);
        chk({tag, "/o_x"}, vp_origin_x, exp_o[0]);
        chk({tag, "/o_y"}, vp_origin_y, exp_o[1]);
        chk({tag, "/o_z"}, vp_origin_z, exp_o[2]);
    endtask

    // One frame job; second_at>0 fires a redundant frame_start sampled at edge k+second_at
    task automatic run_frame(input shortint lx, input shortint ly, input shortint lz,
                             input shortint hx, input shortint hy,
                             input int second_at, input string tag);
        int nvalid;
        lookat_rel_x   = lx;
        lookat_rel_y   = ly;
        lookat_rel_z   = lz;
        lookat_h_rel_x = hx;
        lookat_h_rel_y = hy;
        exp_ax = shortint'($urandom);
        exp_ay = shortint'($urandom);
        p_angle_x = exp_ax;
        p_angle_y = exp_ay;
        model(lx, ly, lz, hx, hy);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk({tag, "/busy_start"}, busy, 1);
        chk({tag, "/ang_x"}, ang_x_o, exp_ax);
        chk({tag, "/ang_y"}, ang_y_o, exp_ay);
        p_angle_x = ~exp_ax;
        p_angle_y = ~exp_ay;
        nvalid = 0;
        for (int n = 1; n <= LAT + 1; n++) begin
            if (n == second_at) frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            if (n == second_at) exp_overrun = 1'b1;
            if (vp_valid === 1'b1) nvalid++;
            if (n == LAT - 1) check_vp({tag, "/held"});
            if (n == LAT) begin
                chk({tag, "/valid"}, vp_valid, 1);
                exp_u = nxt_u;
                exp_v = nxt_v;
                exp_o = nxt_o;
                check_vp(tag);
                chk({tag, "/busy_end"}, busy, 0);
            end
        end
        chk({tag, "/valid_drop"}, vp_valid, 0);
        chk({tag, "/valid_count"}, nvalid, 1);
        chk({tag, "/ang_x_hold"}, ang_x_o, exp_ax);
        chk({tag, "/ang_y_hold"}, ang_y_o, exp_ay);
        chk({tag, "/overrun"}, overrun, exp_overrun);
    endtask

    task automatic check_all_zero(input string tag);
        check_vp(tag);
        chk({tag, "/ang_x"}, ang_x_o, 0);
        chk({tag, "/ang_y"}, ang_y_o, 0);
        chk({tag, "/busy"}, busy, 0);
        chk({tag, "/overrun"}, overrun, 0);
        chk({tag, "/valid"}, vp_valid, 0);
    endtask

    initial begin
        int nvalid;
        shortint rl [5];
        rst = 1'b1;
        frame_start = 1'b0;
        p_angle_x = '0;
        p_angle_y = '0;
        lookat_rel_x = '0;
        lookat_rel_y = '0;
        lookat_rel_z = '0;
        lookat_h_rel_x = '0;
        lookat_h_rel_y = '0;
        exp_u = '{default: 0};
        exp_v = '{default: 0};
        exp_o = '{default: 0};
        exp_overrun = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        run_frame(225, 0, 0, 225, 0, 0, "case1");
        chk("case1/o_y_const", vp_origin_y, 1280);
        chk("case1/v_z_const", vp_v_z, 225);
        run_frame(0, 225, 0, 0, 225, 0, "case2");
        chk("case2/o_x_const", vp_origin_x, -1280);
        run_frame(100, 0, 37, 100, 0, 0, "case3");
        chk("case3/v_x_const", vp_v_x, -16);
        chk("case3/o_z_const", vp_origin_z, 214);
        run_frame(225, 0, 0, 225, 0, 5, "overrun");

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 5; j++) rl[j] = shortint'(int'($urandom_range(0, 600)) - 300);
            run_frame(rl[0], rl[1], rl[2], rl[3], rl[4], 0, $sformatf("rand_small%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 5; j++) rl[j] = shortint'($urandom);
            run_frame(rl[0], rl[1], rl[2], rl[3], rl[4], 0, $sformatf("rand_full%0d", i));
        end
        run_frame(-32768, 32767, -32768, -32768, -32768, 0, "extreme");

        // Reset landing on a frame_start must win
        p_angle_x = 16'sd1234;
        p_angle_y = -16'sd77;
        rst = 1'b1;
        frame_start = 1'b1;
        tick();
        rst = 1'b0;
        frame_start = 1'b0;
        exp_u = '{default: 0};
        exp_v = '{default: 0};
        exp_o = '{default: 0};
        exp_overrun = 1'b0;
        check_all_zero("rst_vs_start");
        tick();
        chk("rst_vs_start/busy_after", busy, 0);

        run_frame(100, 0, 37, 100, 0, 0, "pre_abort");

        // Reset arriving mid-ORIGIN aborts the job
        lookat_rel_x = 225;
        lookat_rel_y = 0;
        lookat_rel_z = 0;
        lookat_h_rel_x = 225;
        lookat_h_rel_y = 0;
        p_angle_x = 16'sd500;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (10) tick();
        chk("abort/busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_u = '{default: 0};
        exp_v = '{default: 0};
        exp_o = '{default: 0};
        check_all_zero("abort");
        nvalid = 0;
        repeat (10) begin
            tick();
            if (vp_valid === 1'b1) nvalid++;
        end
        chk("abort/no_valid", nvalid, 0);
        chk("abort/busy_idle", busy, 0);

        run_frame(0, 225, 0, 0, 225, 0, "post_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
